ntt_coef_unpacker: RTL and testbench
====================================

Name: ntt_coef_unpacker

Overview:
Output-side companion of the NTT operation core: it receives packed 132-bit result words from the core and unpacks them into a 12-bit coefficient stream, one coefficient per cycle, with valid/ready flow control. It frames the stream into polynomials of N coefficients and marks the last coefficient of each polynomial. It sits between the core's result port and the downstream consumer (bench checker or next pipeline stage).

Parameters:
COEF_W, 12, coefficient width (q = 3329 fits in 12 bits)
COEFS_PER_WORD, 11, coefficient slots per input word
WORD_W, 132, input word width; must equal COEF_W*COEFS_PER_WORD
N, 256, coefficients per polynomial

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
clear  in  1  synchronous abort; drops the held word and the polynomial position
word_valid  in  1  input word present
word_ready  out  1  unpacker accepts the word this cycle
word_in  in  WORD_W  packed coefficients; slot 0 at bits [COEF_W-1:0]
coef_valid  out  1  coef_out holds a valid coefficient
coef_ready  in  1  downstream accepts the coefficient this cycle
coef_out  out  COEF_W  current coefficient
coef_idx  out  8  index 0..N-1 of coef_out within the polynomial
coef_last  out  1  high with coef_valid when coef_idx == N-1

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst).
- Reset values:
  - state EMPTY; holding register, slot counter and coef_idx all 0.
  - coef_valid=0, coef_out=0, coef_idx=0, coef_last=0.
  - word_ready=1 once rst deasserts.
- States:
  - EMPTY: no word held. coef_valid=0, word_ready=1.
  - DRAIN: word held. coef_valid=1, coef_out = holding[slot*COEF_W +: COEF_W].
- Input handshake: a word is accepted when word_valid & word_ready at a rising edge.
  - The word is loaded into the holding register, slot is set to 0, and the state goes to DRAIN.
  - Latency is one cycle: the first coefficient is valid in the cycle after acceptance.
- Output handshake: a coefficient is consumed when coef_valid & coef_ready.
  - On consume, slot and coef_idx increment.
  - While coef_ready=0, coef_out, coef_idx and coef_last hold stable.
- End of word: the consumed slot is the final slot of the word when slot==COEFS_PER_WORD-1 or coef_idx==N-1.
  - word_ready = EMPTY | (coef_valid & coef_ready & final slot). This path is combinational and gives gap-free streaming.
  - On the final-slot consume: if a word is accepted in the same cycle, stay in DRAIN with slot=0 and the new word; otherwise go to EMPTY.
- Polynomial framing:
  - When coef_idx==N-1 is consumed, coef_idx wraps to 0.
  - Unused slots of that word are discarded. For the defaults, word 23 carries 3 coefficients; slots 3..10 are dropped.
- Throughput: 1 coefficient/cycle with coef_ready held high. A polynomial takes 24 words and 256 cycles.
- clear: takes priority over everything.
  - Next state is EMPTY; slot=0 and coef_idx=0.
  - word_ready is forced to 0 during the clear cycle, so no word is accepted then.
  - coef_valid=0 from the following cycle.
- Reset mid-operation: all state and outputs go to their reset values immediately (asynchronous). A partial word is lost. No coefficient appears until a new word is accepted.
- Arithmetic: slot counter is ceil(log2(COEFS_PER_WORD)) bits; coef_idx is 8 bits. No saturation; only the wrap rules above apply.

Decomposition:
- Shared ntt package:
  - COEF_W, COEFS_PER_WORD, WORD_W and N, shared with the NTT core and bench.
  - KYBER_Q=3329.
  - Mode codes FORWARD_NTT_MODE=3'd0, INVERSE_NTT_MODE=3'd1.
  - Unpacker state encoding.
- Single module. The slot mux is inline; no sub-module is warranted.

Test Plan:
1. Reset, then one word 132'h0ad046df4803ca8e with coef_ready=1:
   - coef_out sequence 0xa8e, 0x03c, 0xf48, 0x46d, 0xad0, then six 0x000.
   - coef_idx runs 0..10; word_ready is high in the 11th coefficient cycle.
2. 24 back-to-back words, coef_ready=1:
   - 256 coefficients on consecutive cycles; coef_last only at idx 255.
   - Word 23 slots 3..10 never appear.
   - The next word starts again at idx 0.
3. coef_ready toggling 1,0,1,0:
   - Outputs stay stable on stall cycles, with no loss or duplication.
   - word_ready stays 0 until the final-slot handshake.
4. clear at idx 5 with word_valid=1:
   - No acceptance in the clear cycle; coef_valid=0 on the next cycle.
   - The next accepted word emits idx 0.
5. rst pulled low mid-word (idx 7):
   - coef_valid, coef_out and coef_idx go to 0 immediately.
   - After rst releases, no coefficient appears until a new word is accepted.
6. word_valid held high while DRAIN and coef_ready=0:
   - The word is not accepted.
   - Once coef_ready=1, it is accepted exactly on the slot-10 consume cycle, and its slot 0 follows the next cycle.

Source files
------------

// File: rtl/ntt_coef_unpacker_pkg.sv
// Shared NTT constants: coefficient geometry, modulus, mode codes
// and the unpacker state encoding.
package ntt_coef_unpacker_pkg;

    localparam int COEF_W         = 12;
    localparam int COEFS_PER_WORD = 11;
    localparam int WORD_W         = COEF_W * COEFS_PER_WORD;
    localparam int N              = 256;
    localparam int KYBER_Q        = 3329;

    localparam logic [2:0] FORWARD_NTT_MODE = 3'd0;
    localparam logic [2:0] INVERSE_NTT_MODE = 3'd1;

    typedef enum logic {
        UNPK_EMPTY = 1'b0,
        UNPK_DRAIN = 1'b1
    } unpk_state_t;

endpackage

// File: rtl/ntt_coef_unpacker.sv
// Unpacks packed NTT result words into a framed coefficient stream,
// one coefficient per cycle with valid/ready on both sides.
module ntt_coef_unpacker #(
    parameter int COEF_W         = ntt_coef_unpacker_pkg::COEF_W,
    parameter int COEFS_PER_WORD = ntt_coef_unpacker_pkg::COEFS_PER_WORD,
    parameter int WORD_W         = ntt_coef_unpacker_pkg::WORD_W,
    parameter int N              = ntt_coef_unpacker_pkg::N
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              word_valid,
    output logic              word_ready,
    input  logic [WORD_W-1:0] word_in,
    output logic              coef_valid,
    input  logic              coef_ready,
    output logic [COEF_W-1:0] coef_out,
    output logic [7:0]        coef_idx,
    output logic              coef_last
);

    import ntt_coef_unpacker_pkg::*;

    localparam int SLOT_W = $clog2(COEFS_PER_WORD);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(COEFS_PER_WORD - 1);
    localparam logic [7:0] LAST_IDX = 8'(N - 1);

    unpk_state_t       state, state_nxt;
    logic [WORD_W-1:0] holding, holding_nxt;
    logic [SLOT_W-1:0] slot, slot_nxt;
    logic [7:0]        idx, idx_nxt;
    logic              consume;
    logic              final_slot;
    logic              accept;

    assign coef_valid = (state == UNPK_DRAIN);
    assign coef_idx   = idx;
    assign coef_last  = coef_valid & (idx == LAST_IDX);
    assign consume    = coef_valid & coef_ready;
    assign final_slot = (slot == LAST_SLOT) | (idx == LAST_IDX);

    // Refill in the same cycle as the last consume keeps the stream gap-free
    assign word_ready = ~clear & (~coef_valid | (consume & final_slot));
    assign accept     = word_valid & word_ready;

    always_comb begin
        coef_out = '0;
        for (int i = 0; i < COEFS_PER_WORD; i++) begin
            if (coef_valid && slot == SLOT_W'(i)) begin
                coef_out = holding[i*COEF_W +: COEF_W];
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        holding_nxt = holding;
        slot_nxt    = slot;
        idx_nxt     = idx;
        if (consume) begin
            slot_nxt = slot + 1'b1;
            idx_nxt  = (idx == LAST_IDX) ? '0 : idx + 1'b1;
            if (final_slot) begin
                state_nxt = UNPK_EMPTY;
                slot_nxt  = '0;
            end
        end
        if (accept) begin
            state_nxt   = UNPK_DRAIN;
            holding_nxt = word_in;
            slot_nxt    = '0;
        end
        if (clear) begin
            state_nxt   = UNPK_EMPTY;
            holding_nxt = '0;
            slot_nxt    = '0;
            idx_nxt     = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= UNPK_EMPTY;
            holding <= '0;
            slot    <= '0;
            idx     <= '0;
        end else begin
            state   <= state_nxt;
            holding <= holding_nxt;
            slot    <= slot_nxt;
            idx     <= idx_nxt;
        end
    end

endmodule

// File: tb/tb_ntt_coef_unpacker.sv
// Directed bench for ntt_coef_unpacker: inputs change 1ns after the
// rising edge, outputs are compared 2ns after it.
module tb_ntt_coef_unpacker;

    import ntt_coef_unpacker_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              clear;
    logic              word_valid;
    logic              word_ready;
    logic [WORD_W-1:0] word_in;
    logic              coef_valid;
    logic              coef_ready;
    logic [COEF_W-1:0] coef_out;
    logic [7:0]        coef_idx;
    logic              coef_last;

    int vectors = 0;
    int miscompares = 0;

    logic [WORD_W-1:0] words [0:25];
    logic [WORD_W-1:0] w1, wa, wb;
    logic [COEF_W-1:0] exp1 [0:10];
    int wi;
    bit fin;

    always #5 clk = ~clk;

    ntt_coef_unpacker dut (
        .clk(clk),
        .rst(rst),
        .clear(clear),
        .word_valid(word_valid),
        .word_ready(word_ready),
        .word_in(word_in),
        .coef_valid(coef_valid),
        .coef_ready(coef_ready),
        .coef_out(coef_out),
        .coef_idx(coef_idx),
        .coef_last(coef_last)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [COEF_W-1:0] cv(input int c);
        return COEF_W'(c * 13 + 1);
    endfunction

    function automatic logic [WORD_W-1:0] mkword(input int j);
        logic [WORD_W-1:0] w;
        w = '0;
        for (int s = 0; s < COEFS_PER_WORD; s++)
            w[s*COEF_W +: COEF_W] = cv(j * COEFS_PER_WORD + s);
        return w;
    endfunction

    function automatic logic [COEF_W-1:0] slot_of(
        input logic [WORD_W-1:0] w, input int s);
        return w[s*COEF_W +: COEF_W];
    endfunction

    task automatic clear_pulse();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        #1;
        check("clr_idx", coef_idx, 0);
        check("clr_val", coef_valid, 0);
        tick();
    endtask

    task automatic drain(input logic [WORD_W-1:0] w, input int idx0);
        for (int s = 0; s < COEFS_PER_WORD; s++) begin
            coef_ready = 1'b1;
            word_valid = 1'b0;
            #1;
            check("drn_val", coef_valid, 1);
            check("drn_out", coef_out, slot_of(w, s));
            check("drn_idx", coef_idx, 8'(idx0 + s));
            check("drn_wrdy", word_ready, s == COEFS_PER_WORD - 1);
            tick();
        end
        #1;
        check("drn_empty", coef_valid, 0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        clear = 1'b0;
        word_valid = 1'b0;
        coef_ready = 1'b0;
        word_in = '0;
        w1 = 132'h0ad046df4803ca8e;
        exp1 = '{12'ha8e, 12'h03c, 12'hf48, 12'h46d, 12'had0,
                 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000};
        #3;
        check("rst_val", coef_valid, 0);
        check("rst_out", coef_out, 0);
        check("rst_idx", coef_idx, 0);
        check("rst_last", coef_last, 0);
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("rst_wrdy", word_ready, 1);
        tick();

        // single word, hand-computed slots
        word_valid = 1'b1;
        word_in = w1;
        tick();
        word_valid = 1'b0;
        coef_ready = 1'b1;
        for (int k = 0; k < COEFS_PER_WORD; k++) begin
            #1;
            check("t1_val", coef_valid, 1);
            check("t1_out", coef_out, exp1[k]);
            check("t1_idx", coef_idx, k);
            check("t1_wrdy", word_ready, k == 10);
            tick();
        end
        #1;
        check("t1_empty", coef_valid, 0);
        tick();
        clear_pulse();

        // full polynomial, back-to-back words
        for (int j = 0; j < 26; j++) words[j] = mkword(j);
        for (int s = 3; s < COEFS_PER_WORD; s++)
            words[23][s*COEF_W +: COEF_W] = 12'hfff;
        words[24] = mkword(40);
        wi = 0;
        word_valid = 1'b1;
        word_in = words[0];
        coef_ready = 1'b1;
        tick();
        wi = 1;
        word_in = words[1];
        for (int c = 0; c < N; c++) begin
            #1;
            fin = (c % COEFS_PER_WORD == 10) || (c == N - 1);
            check("t2_val", coef_valid, 1);
            check("t2_idx", coef_idx, c);
            check("t2_out", coef_out, cv(c));
            check("t2_last", coef_last, c == N - 1);
            check("t2_wrdy", word_ready, fin);
            tick();
            if (fin) begin
                wi++;
                word_in = words[wi];
            end
            if (c == N - 1) word_valid = 1'b0;
        end
        drain(words[24], 0);
        clear_pulse();

        // ready toggling 1,0,1,0
        wa = mkword(50);
        word_valid = 1'b1;
        word_in = wa;
        coef_ready = 1'b0;
        tick();
        word_valid = 1'b0;
        for (int n = 0; n < 21; n++) begin
            coef_ready = (n % 2 == 0);
            #1;
            check("t3_val", coef_valid, 1);
            check("t3_out", coef_out, slot_of(wa, (n + 1) / 2));
            check("t3_idx", coef_idx, (n + 1) / 2);
            check("t3_wrdy", word_ready, n == 20);
            tick();
        end
        #1;
        check("t3_empty", coef_valid, 0);
        tick();
        clear_pulse();

        // clear at idx 5 with a word waiting
        wa = mkword(60);
        wb = mkword(70);
        word_valid = 1'b1;
        word_in = wa;
        coef_ready = 1'b1;
        tick();
        word_valid = 1'b0;
        for (int s = 0; s < 5; s++) begin
            #1;
            check("t4_out", coef_out, slot_of(wa, s));
            check("t4_idx", coef_idx, s);
            tick();
        end
        clear = 1'b1;
        word_valid = 1'b1;
        word_in = wb;
        #1;
        check("t4_clr_wrdy", word_ready, 0);
        check("t4_clr_idx", coef_idx, 5);
        tick();
        clear = 1'b0;
        word_valid = 1'b0;
        #1;
        check("t4_post_val", coef_valid, 0);
        check("t4_post_idx", coef_idx, 0);
        tick();
        word_valid = 1'b1;
        #1;
        check("t4_wrdy", word_ready, 1);
        tick();
        word_valid = 1'b0;
        #1;
        check("t4_new_val", coef_valid, 1);
        check("t4_new_idx", coef_idx, 0);
        check("t4_new_out", coef_out, slot_of(wb, 0));
        tick();
        clear_pulse();

        // asynchronous reset at idx 7
        wa = mkword(80);
        word_valid = 1'b1;
        word_in = wa;
        coef_ready = 1'b1;
        tick();
        word_valid = 1'b0;
        for (int s = 0; s < 8; s++) begin
            #1;
            check("t5_idx", coef_idx, s);
            check("t5_out", coef_out, slot_of(wa, s));
            if (s < 7) tick();
        end
        rst = 1'b0;
        #1;
        check("t5_rst_val", coef_valid, 0);
        check("t5_rst_out", coef_out, 0);
        check("t5_rst_idx", coef_idx, 0);
        check("t5_rst_last", coef_last, 0);
        tick();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("t5_idle_val", coef_valid, 0);
            tick();
        end

        // word_valid held high during a stalled drain
        wa = mkword(90);
        wb = mkword(100);
        word_valid = 1'b1;
        word_in = wa;
        coef_ready = 1'b0;
        tick();
        word_in = wb;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("t6_stall_wrdy", word_ready, 0);
            check("t6_stall_out", coef_out, slot_of(wa, 0));
            check("t6_stall_idx", coef_idx, 0);
            tick();
        end
        coef_ready = 1'b1;
        for (int s = 0; s < COEFS_PER_WORD; s++) begin
            #1;
            check("t6_out", coef_out, slot_of(wa, s));
            check("t6_idx", coef_idx, s);
            check("t6_wrdy", word_ready, s == 10);
            tick();
        end
        word_valid = 1'b0;
        #1;
        check("t6_next_val", coef_valid, 1);
        check("t6_next_out", coef_out, slot_of(wb, 0));
        check("t6_next_idx", coef_idx, 11);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
